// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared encodings and defaults for the core-to-unified-memory arbiter
package cpu_mem_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_DONE = 2'd2
  } state_e;
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;
  localparam int DEF_LAT        = 2;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_lat_timer.sv
// mem_lat_timer: loadable 4-bit down-counter that stops at zero and flags it
module mem_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic       done_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  assign done_o = cnt_q == 4'd0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first,
// with a starvation guard that lets a waiting fetch win after STARVE_MAX data grants.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = DEF_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    starve_q, starve_d;
  logic          if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          idle, gnt_if, gnt_d, rd_start, lat_done;

  assign idle     = state_q == IDLE;
  assign gnt_if   = idle & if_req & (~d_req | (starve_q == 4'(STARVE_MAX)));
  assign gnt_d    = idle & d_req & ~gnt_if;
  assign rd_start = gnt_if | (gnt_d & ~|d_we);

  mem_lat_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (rd_start),
    .val_i  (4'(LAT - 1)),
    .done_o (lat_done)
  );

  // A store retires straight back to IDLE, so WR_DONE never becomes a visible state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d = RD_WAIT;
          owner_d = gnt_d ? OWNER_D : OWNER_IF;
        end else if (gnt_d) begin
          d_valid_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (lat_done) begin
          state_d = IDLE;
          if (owner_q == OWNER_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    starve_d = gnt_if ? 4'd0
             : (gnt_d & if_req & (starve_q != 4'(STARVE_MAX))) ? starve_q + 4'd1
             : starve_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_IF;
      starve_q   <= 4'd0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = gnt_if | gnt_d;
  assign mem_we    = gnt_d ? d_we : 4'b0000;
  assign mem_addr  = gnt_d ? d_addr : if_addr;
  assign mem_wdata = d_wdata;
  assign busy      = ~idle;
endmodule
